// File: rtl/jpeg_blk_seq_if.sv
// Stream and core-side signal bundle for the JPEG block sequencer.
// The sequencer uses the slave view; whatever feeds samples, hosts the
// DCT/quantise core and sinks coefficients uses the master view.
interface jpeg_blk_seq_if #(
    parameter int DW = 12
);
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic [64*DW-1:0] core_in;
    logic [64*DW-1:0] core_out;
    logic             core_valid;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output in_data, in_valid,
        input  in_ready,
        input  core_in,
        output core_out, core_valid,
        input  out_data, out_valid, out_last,
        output out_ready
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready,
        output core_in,
        input  core_out, core_valid,
        output out_data, out_valid, out_last,
        input  out_ready
    );
endinterface

// File: rtl/jpeg_blk_seq.sv
// jpeg_blk_seq: sequencer in front of the 8x8 DCT/quantise core.
// Collects 64 raster-order samples, holds them on core_in while the core
// works, captures the 64 results and streams them out in raster or
// zig-zag order. Exactly one block is in flight at any time.
module jpeg_blk_seq #(
    parameter int DW       = 12,
    parameter int WAIT_MIN = 2,
    parameter int TIMEOUT  = 1024,
    parameter bit ZIGZAG   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    jpeg_blk_seq_if.slave bus,
    output logic          busy,
    output logic          err,
    output logic [15:0]   blk_cnt
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_FIRST = WCW'(WAIT_MIN);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);

    // Standard JPEG zig-zag scan: beat number -> raster position.
    localparam logic [5:0] ZZ_ROM [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       fill_idx;
    logic [5:0]       drain_idx;
    logic [WCW-1:0]   wait_cnt;
    logic [DW-1:0]    in_buf  [64];
    logic [DW-1:0]    out_buf [64];
    logic [DW-1:0]    core_out_w [64];
    logic [64*DW-1:0] core_in_flat;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [DW-1:0]    out_data_q;
    logic             in_fire;
    logic             valid_hit;
    logic             time_hit;
    logic             capture;
    logic             out_fire;

    // Raster position of a given output beat in the selected drain order.
    function automatic logic [5:0] beat_map(input logic [5:0] beat);
        return ZIGZAG ? ZZ_ROM[beat] : beat;
    endfunction

    assign in_fire   = (state == S_FILL) && in_ready_q && bus.in_valid;
    assign valid_hit = (state == S_RUN) && (wait_cnt >= WAIT_FIRST) && bus.core_valid;
    assign time_hit  = (state == S_RUN) && (wait_cnt == WAIT_LAST);
    assign capture   = valid_hit || time_hit;
    assign out_fire  = (state == S_DRAIN) && out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.core_in   = core_in_flat;

    // Flatten the input buffer onto the core bus, sample k at bits [k*DW +: DW].
    always_comb begin
        core_in_flat = '0;
        for (int k = 0; k < 64; k++) begin
            core_in_flat[k*DW +: DW] = in_buf[k];
        end
    end

    // Unpack the core result bus into per-coefficient words.
    always_comb begin
        for (int k = 0; k < 64; k++) begin
            core_out_w[k] = bus.core_out[k*DW +: DW];
        end
    end

    // Next-state decode; busy simply reflects being past the fill phase.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        unique case (state)
            S_FILL: begin
                if (in_fire && (fill_idx == 6'd63)) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (capture) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (out_fire && out_last_q) state_nxt = S_FILL;
            end
            default: begin
                state_nxt = S_FILL;
            end
        endcase
    end

    // State register; in_ready is registered so it stays low through reset
    // and rises on the first edge that lands the FSM in FILL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_FILL;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt == S_FILL);
        end
    end

    // Input deserialiser: only FILL transfers ever touch in_buf.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_idx <= '0;
            for (int k = 0; k < 64; k++) begin
                in_buf[k] <= '0;
            end
        end else if (in_fire) begin
            in_buf[fill_idx] <= bus.in_data;
            fill_idx         <= fill_idx + 6'd1;
        end
    end

    // RUN cycle counter: held at zero while filling, stops once captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == S_FILL) begin
            wait_cnt <= '0;
        end else if ((state == S_RUN) && !capture) begin
            wait_cnt <= wait_cnt + WCW'(1);
        end
    end

    // Snapshot of the core result, taken on the capture edge only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 64; k++) begin
                out_buf[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < 64; k++) begin
                out_buf[k] <= core_out_w[k];
            end
        end
    end

    // Output serialiser: beat 0 comes straight from core_out on the capture
    // edge since out_buf is being written on that same edge; later beats
    // come from out_buf and only advance on an accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            drain_idx   <= '0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            out_data_q  <= core_out_w[beat_map(6'd0)];
            drain_idx   <= 6'd1;
        end else if (out_fire) begin
            if (out_last_q) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                out_data_q  <= '0;
                drain_idx   <= '0;
            end else begin
                out_data_q  <= out_buf[beat_map(drain_idx)];
                out_last_q  <= (drain_idx == 6'd63);
                drain_idx   <= drain_idx + 6'd1;
            end
        end
    end

    // Sticky timeout flag and completed-block counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err     <= 1'b0;
            blk_cnt <= '0;
        end else begin
            if (time_hit && !valid_hit) err <= 1'b1;
            if (out_fire && out_last_q) blk_cnt <= blk_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_jpeg_blk_seq.sv
// Testbench for jpeg_blk_seq: a raster-order and a zig-zag-order instance
// run side by side on identical stimulus, each against a reference model
// built from the block contents and a diagonal-walk zig-zag scan.
module tb_jpeg_blk_seq;

    localparam int DW       = 12;
    localparam int WAIT_MIN = 2;
    localparam int TIMEOUT  = 1024;
    localparam int CORE_LAT = 5;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    int            core_mode = 0;
    logic          core_valid_m;
    int            run_cnt;
    logic          busy_r, busy_z, err_r, err_z;
    logic [15:0]   cnt_r, cnt_z;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    int            zz [64];
    logic [DW-1:0] blk [64];
    logic [DW-1:0] got_r [64];
    logic [DW-1:0] got_z [64];
    logic          lst_r [64];
    logic          lst_z [64];
    int            nr, nz, sent, hold_bad, in_ready_bad, fill_bad;
    int            first_r, first_z, last_in_edge;
    int            exp_cnt = 0;

    jpeg_blk_seq_if #(.DW(DW)) bus_r ();
    jpeg_blk_seq_if #(.DW(DW)) bus_z ();

    jpeg_blk_seq #(.DW(DW), .WAIT_MIN(WAIT_MIN), .TIMEOUT(TIMEOUT), .ZIGZAG(1'b0)) dut_r (
        .clk(clk), .rst(rst), .bus(bus_r), .busy(busy_r), .err(err_r), .blk_cnt(cnt_r)
    );

    jpeg_blk_seq #(.DW(DW), .WAIT_MIN(WAIT_MIN), .TIMEOUT(TIMEOUT), .ZIGZAG(1'b1)) dut_z (
        .clk(clk), .rst(rst), .bus(bus_z), .busy(busy_z), .err(err_z), .blk_cnt(cnt_z)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: echoes its input; valid is a single pulse CORE_LAT cycles
    // into the busy period (mode 0), stuck high (mode 1) or stuck low (mode 2).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_cnt <= 0;
        else      run_cnt <= busy_r ? run_cnt + 1 : 0;
    end

    always_comb begin
        core_valid_m = (core_mode == 1) || ((core_mode == 0) && busy_r && (run_cnt == CORE_LAT));
    end

    assign bus_r.in_data    = in_data;
    assign bus_r.in_valid   = in_valid;
    assign bus_r.out_ready  = out_ready;
    assign bus_r.core_out   = bus_r.core_in;
    assign bus_r.core_valid = core_valid_m;
    assign bus_z.in_data    = in_data;
    assign bus_z.in_valid   = in_valid;
    assign bus_z.out_ready  = out_ready;
    assign bus_z.core_out   = bus_z.core_in;
    assign bus_z.core_valid = core_valid_m;

    // Zig-zag order generated by walking the anti-diagonals of the 8x8 block.
    function automatic void build_zigzag();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            for (int r = 0; r < 8; r++) begin
                int row;
                int col;
                row = (s % 2 == 0) ? 7 - r : r;
                col = s - row;
                if (col >= 0 && col < 8) begin
                    zz[n] = row * 8 + col;
                    n++;
                end
            end
        end
    endfunction

    // Feed one 64-sample block, recording what was actually accepted.
    task automatic send_block(input bit ramp, input int gap_pct);
        int budget = 0;
        sent     = 0;
        fill_bad = 0;
        while (sent < 64 && budget < 4000) begin
            @(negedge clk);
            budget++;
            out_ready = 1'($urandom_range(1));
            in_valid  = ($urandom_range(99) >= gap_pct);
            in_data   = ramp ? DW'(sent) : DW'($urandom);
            if (bus_r.out_valid || bus_z.out_valid || (bus_r.in_ready !== bus_z.in_ready)) fill_bad++;
            if (in_valid && bus_r.in_ready) begin
                blk[sent] = in_data;
                sent++;
                if (sent == 64) last_in_edge = cyc + 1;
            end
        end
    endtask

    // Collect output beats until stop_at beats per instance, watching for
    // changes while stalled and for in_ready rising before the block ends.
    task automatic drain_block(input int rdy_pct, input int stop_at);
        int            budget = 0;
        logic          stall_r = 1'b0;
        logic          stall_z = 1'b0;
        logic [DW-1:0] pd_r = '0;
        logic [DW-1:0] pd_z = '0;
        logic          pl_r = 1'b0;
        logic          pl_z = 1'b0;
        nr = 0; nz = 0; hold_bad = 0; in_ready_bad = 0; first_r = -1; first_z = -1;
        for (int i = 0; i < 64; i++) begin
            got_r[i] = 'x; got_z[i] = 'x; lst_r[i] = 1'bx; lst_z[i] = 1'bx;
        end
        while ((nr < stop_at || nz < stop_at) && budget < TIMEOUT + 4000) begin
            @(negedge clk);
            budget++;
            out_ready = ($urandom_range(99) < rdy_pct);
            in_valid  = 1'($urandom_range(1));
            in_data   = DW'($urandom);
            if (bus_r.in_ready || bus_z.in_ready) in_ready_bad++;
            if (bus_r.out_valid && first_r < 0) first_r = cyc;
            if (stall_r && (!bus_r.out_valid || bus_r.out_data !== pd_r || bus_r.out_last !== pl_r)) hold_bad++;
            stall_r = bus_r.out_valid && !out_ready;
            pd_r    = bus_r.out_data;
            pl_r    = bus_r.out_last;
            if (bus_r.out_valid && out_ready) begin
                if (nr < 64) begin got_r[nr] = bus_r.out_data; lst_r[nr] = bus_r.out_last; end
                nr++;
            end
            if (bus_z.out_valid && first_z < 0) first_z = cyc;
            if (stall_z && (!bus_z.out_valid || bus_z.out_data !== pd_z || bus_z.out_last !== pl_z)) hold_bad++;
            stall_z = bus_z.out_valid && !out_ready;
            pd_z    = bus_z.out_data;
            pl_z    = bus_z.out_last;
            if (bus_z.out_valid && out_ready) begin
                if (nz < 64) begin got_z[nz] = bus_z.out_data; lst_z[nz] = bus_z.out_last; end
                nz++;
            end
        end
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        core_mode = 0;
        rst       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            in_data = DW'($urandom);
        end
        rst = 1'b0;
        exp_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({bus_r.in_ready, bus_r.out_valid, bus_r.out_last, busy_r, err_r, cnt_r, bus_r.out_data, bus_r.core_in,
                 bus_z.in_ready, bus_z.out_valid, bus_z.out_last, busy_z, err_z, cnt_z, bus_z.out_data, bus_z.core_in} !== '0)
                $display("[TB] FAIL reset_outputs cycle %0d: flags r=%b z=%b cnt %h/%h data %h/%h core_in_nonzero %b/%b, want all 0",
                         c, {bus_r.in_ready, bus_r.out_valid, bus_r.out_last, busy_r, err_r},
                         {bus_z.in_ready, bus_z.out_valid, bus_z.out_last, busy_z, err_z},
                         cnt_r, cnt_z, bus_r.out_data, bus_z.out_data, |bus_r.core_in, |bus_z.core_in);
            else passed++;
            @(negedge clk);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({bus_r.in_ready, bus_z.in_ready} !== 2'b00)
            $display("[TB] FAIL reset_release_ready: in_ready %b, want 00", {bus_r.in_ready, bus_z.in_ready});
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if ({bus_r.in_ready, bus_z.in_ready} !== 2'b11)
            $display("[TB] FAIL reset_first_edge_ready: in_ready %b, want 11", {bus_r.in_ready, bus_z.in_ready});
        else passed++;
    endtask

    task automatic test_ramp();
        logic [DW-1:0] zz_head [8];
        zz_head = '{12'd0, 12'd1, 12'd8, 12'd16, 12'd9, 12'd2, 12'd3, 12'd10};
        core_mode = 0;
        send_block(1'b1, 0);
        drain_block(100, 64);
        exp_cnt++;
        checks++;
        if ({sent, nr, nz, fill_bad, hold_bad, in_ready_bad} !== {32'd64, 32'd64, 32'd64, 32'd0, 32'd0, 32'd0})
            $display("[TB] FAIL ramp_counts: sent %0d beats %0d/%0d fill_bad %0d hold_bad %0d ready_bad %0d, want 64 64/64 0 0 0",
                     sent, nr, nz, fill_bad, hold_bad, in_ready_bad);
        else passed++;
        checks++;
        if ({first_r - last_in_edge, first_z - last_in_edge} !== {CORE_LAT + 1, CORE_LAT + 1})
            $display("[TB] FAIL ramp_latency: %0d/%0d cycles, want %0d", first_r - last_in_edge, first_z - last_in_edge, CORE_LAT + 1);
        else passed++;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if ({got_r[i], lst_r[i], got_z[i], lst_z[i]} !== {blk[i], i == 63, blk[zz[i]], i == 63})
                $display("[TB] FAIL ramp_beat %0d: raster %h/%b zigzag %h/%b, want %h/%b %h/%b",
                         i, got_r[i], lst_r[i], got_z[i], lst_z[i], blk[i], i == 63, blk[zz[i]], i == 63);
            else passed++;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_z[i] !== zz_head[i])
                $display("[TB] FAIL zigzag_head %0d: got %0d, want %0d", i, got_z[i], zz_head[i]);
            else passed++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({bus_r.out_valid, bus_z.out_valid, bus_r.in_ready, bus_z.in_ready, busy_r, busy_z, err_r, err_z, cnt_r, cnt_z}
            !== {8'b0011_0000, 16'(exp_cnt), 16'(exp_cnt)})
            $display("[TB] FAIL ramp_after: flags %b cnt %0d/%0d, want 00110000 cnt %0d",
                     {bus_r.out_valid, bus_z.out_valid, bus_r.in_ready, bus_z.in_ready, busy_r, busy_z, err_r, err_z}, cnt_r, cnt_z, exp_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        core_mode = 0;
        for (int b = 0; b < 3; b++) begin
            send_block(1'b0, 40);
            drain_block(50, 64);
            exp_cnt++;
            checks++;
            if ({sent, nr, nz, fill_bad, hold_bad, in_ready_bad} !== {32'd64, 32'd64, 32'd64, 32'd0, 32'd0, 32'd0})
                $display("[TB] FAIL b2b_counts blk %0d: sent %0d beats %0d/%0d fill_bad %0d hold_bad %0d ready_bad %0d, want 64 64/64 0 0 0",
                         b, sent, nr, nz, fill_bad, hold_bad, in_ready_bad);
            else passed++;
            for (int i = 0; i < 64; i++) begin
                checks++;
                if ({got_r[i], lst_r[i], got_z[i], lst_z[i]} !== {blk[i], i == 63, blk[zz[i]], i == 63})
                    $display("[TB] FAIL b2b_beat %0d.%0d: raster %h/%b zigzag %h/%b, want %h/%b %h/%b",
                             b, i, got_r[i], lst_r[i], got_z[i], lst_z[i], blk[i], i == 63, blk[zz[i]], i == 63);
                else passed++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if ({bus_r.out_valid, bus_z.out_valid, bus_r.in_ready, bus_z.in_ready, busy_r, busy_z, err_r, err_z, cnt_r, cnt_z}
                !== {8'b0011_0000, 16'(exp_cnt), 16'(exp_cnt)})
                $display("[TB] FAIL b2b_after blk %0d: flags %b cnt %0d/%0d, want 00110000 cnt %0d",
                         b, {bus_r.out_valid, bus_z.out_valid, bus_r.in_ready, bus_z.in_ready, busy_r, busy_z, err_r, err_z}, cnt_r, cnt_z, exp_cnt);
            else passed++;
        end
    endtask

    task automatic test_stale_valid();
        core_mode = 1;
        for (int b = 0; b < 2; b++) begin
            send_block(1'b0, 0);
            drain_block(70, 64);
            exp_cnt++;
            checks++;
            if ({first_r - last_in_edge, first_z - last_in_edge} !== {WAIT_MIN + 1, WAIT_MIN + 1})
                $display("[TB] FAIL stale_latency blk %0d: %0d/%0d cycles, want %0d",
                         b, first_r - last_in_edge, first_z - last_in_edge, WAIT_MIN + 1);
            else passed++;
            checks++;
            if ({nr, nz, hold_bad} !== {32'd64, 32'd64, 32'd0})
                $display("[TB] FAIL stale_counts blk %0d: beats %0d/%0d hold_bad %0d, want 64/64 0", b, nr, nz, hold_bad);
            else passed++;
            for (int i = 0; i < 64; i++) begin
                checks++;
                if ({got_r[i], lst_r[i], got_z[i], lst_z[i]} !== {blk[i], i == 63, blk[zz[i]], i == 63})
                    $display("[TB] FAIL stale_beat %0d.%0d: raster %h/%b zigzag %h/%b, want %h/%b %h/%b",
                             b, i, got_r[i], lst_r[i], got_z[i], lst_z[i], blk[i], i == 63, blk[zz[i]], i == 63);
                else passed++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if ({err_r, err_z, cnt_r, cnt_z} !== {2'b00, 16'(exp_cnt), 16'(exp_cnt)})
                $display("[TB] FAIL stale_after blk %0d: err %b%b cnt %0d/%0d, want 00 cnt %0d", b, err_r, err_z, cnt_r, cnt_z, exp_cnt);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        for (int b = 0; b < 2; b++) begin
            core_mode = (b == 0) ? 2 : 0;
            send_block(1'b0, 20);
            drain_block(60, 64);
            exp_cnt++;
            checks++;
            if ((b == 0) && ({first_r - last_in_edge, first_z - last_in_edge} !== {TIMEOUT, TIMEOUT}))
                $display("[TB] FAIL timeout_latency: %0d/%0d cycles, want %0d", first_r - last_in_edge, first_z - last_in_edge, TIMEOUT);
            else passed++;
            checks++;
            if ({nr, nz, hold_bad} !== {32'd64, 32'd64, 32'd0})
                $display("[TB] FAIL timeout_counts blk %0d: beats %0d/%0d hold_bad %0d, want 64/64 0", b, nr, nz, hold_bad);
            else passed++;
            for (int i = 0; i < 64; i++) begin
                checks++;
                if ({got_r[i], lst_r[i], got_z[i], lst_z[i]} !== {blk[i], i == 63, blk[zz[i]], i == 63})
                    $display("[TB] FAIL timeout_beat %0d.%0d: raster %h/%b zigzag %h/%b, want %h/%b %h/%b",
                             b, i, got_r[i], lst_r[i], got_z[i], lst_z[i], blk[i], i == 63, blk[zz[i]], i == 63);
                else passed++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if ({err_r, err_z, cnt_r, cnt_z} !== {2'b11, 16'(exp_cnt), 16'(exp_cnt)})
                $display("[TB] FAIL timeout_after blk %0d: err %b%b cnt %0d/%0d, want 11 cnt %0d", b, err_r, err_z, cnt_r, cnt_z, exp_cnt);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_drain();
        core_mode = 0;
        send_block(1'b0, 0);
        drain_block(100, 30);
        for (int i = 0; i < 30; i++) begin
            checks++;
            if ({got_r[i], got_z[i]} !== {blk[i], blk[zz[i]]})
                $display("[TB] FAIL middrain_beat %0d: raster %h zigzag %h, want %h %h", i, got_r[i], got_z[i], blk[i], blk[zz[i]]);
            else passed++;
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        checks++;
        if ({bus_r.in_ready, bus_r.out_valid, bus_r.out_last, busy_r, err_r, cnt_r, bus_r.out_data,
             bus_z.in_ready, bus_z.out_valid, bus_z.out_last, busy_z, err_z, cnt_z, bus_z.out_data} !== '0)
            $display("[TB] FAIL middrain_reset: flags r=%b z=%b cnt %h/%h data %h/%h, want all 0",
                     {bus_r.in_ready, bus_r.out_valid, bus_r.out_last, busy_r, err_r},
                     {bus_z.in_ready, bus_z.out_valid, bus_z.out_last, busy_z, err_z},
                     cnt_r, cnt_z, bus_r.out_data, bus_z.out_data);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        send_block(1'b0, 20);
        drain_block(60, 64);
        exp_cnt++;
        checks++;
        if ({nr, nz, hold_bad} !== {32'd64, 32'd64, 32'd0})
            $display("[TB] FAIL after_reset_counts: beats %0d/%0d hold_bad %0d, want 64/64 0", nr, nz, hold_bad);
        else passed++;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if ({got_r[i], lst_r[i], got_z[i], lst_z[i]} !== {blk[i], i == 63, blk[zz[i]], i == 63})
                $display("[TB] FAIL after_reset_beat %0d: raster %h/%b zigzag %h/%b, want %h/%b %h/%b",
                         i, got_r[i], lst_r[i], got_z[i], lst_z[i], blk[i], i == 63, blk[zz[i]], i == 63);
            else passed++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({err_r, err_z, cnt_r, cnt_z} !== {2'b00, 16'd1, 16'd1})
            $display("[TB] FAIL after_reset_status: err %b%b cnt %0d/%0d, want 00 cnt 1", err_r, err_z, cnt_r, cnt_z);
        else passed++;
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        build_zigzag();
        test_reset();
        test_ramp();
        test_back_to_back();
        test_stale_valid();
        test_timeout();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Hard stop in case the design wedges somewhere no per-task bound catches.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/jpeg_blk_seq.md
Name: jpeg_blk_seq

Overview:
- Sequencer in front of the 8x8 JPEG DCT/quantise core.
- Deserialises a 12-bit sample stream into one 64-sample block and presents it to the core as a flat bus.
- Waits for the core's valid, captures the 64 results, then serialises them onto an output stream in raster or zig-zag order.
- Handles one block at a time; reports per-block timeout errors and a completed-block count.

Parameters:
- DW, 12, sample width in and out.
- WAIT_MIN, 2, cycles after RUN entry during which core_valid is ignored (masks stale valid from the previous block).
- TIMEOUT, 1024, maximum cycles in RUN before forced capture.
- ZIGZAG, 1, 1 = drain in JPEG zig-zag order, 0 = raster order.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  DW  input sample, raster order (index 0 first).
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts a sample; transfer when in_valid && in_ready.
- core_in  out  64*DW  block to core; sample k at bits [k*DW +: DW].
- core_out  in  64*DW  core result, same packing.
- core_valid  in  1  core result valid.
- out_data  out  DW  output coefficient.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- out_last  out  1  high with the 64th beat of a block.
- busy  out  1  high in RUN or DRAIN.
- err  out  1  sticky: a timeout occurred; cleared only by reset.
- blk_cnt  out  16  blocks fully drained; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst=0, async): state=FILL; fill index, drain index and wait counter = 0.
- Reset values: in_ready=0 while rst=0; core_in, out_data, out_valid, out_last, busy, err, blk_cnt all 0.
- Internal buffers: in_buf (64xDW, drives core_in directly) and out_buf (64xDW). They are separate registers.
- FILL:
  - in_ready=1.
  - Each transfer writes in_buf[fill_idx] and increments fill_idx.
  - The transfer with fill_idx=63 moves to RUN next cycle and clears wait_cnt.
  - in_buf is written only in FILL.
- RUN:
  - in_ready=0; busy=1; core_in held stable; wait_cnt increments each cycle.
  - If wait_cnt >= WAIT_MIN and core_valid=1: capture core_out into out_buf on that edge and go to DRAIN.
  - If wait_cnt reaches TIMEOUT-1 with no qualifying valid: capture core_out as-is, set err=1, go to DRAIN.
  - Valid and timeout on the same cycle counts as a valid capture; err is not set.
- DRAIN:
  - out_valid=1 from the cycle after capture.
  - Beat i presents out_buf[map(i)]; map(i)=i when ZIGZAG=0.
  - When ZIGZAG=1, map is the standard JPEG zig-zag sequence 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63, implemented as a constant ROM.
  - out_data, out_valid and out_last are registered and held unchanged while out_ready=0.
  - out_last=1 only for beat 63.
  - On the beat-63 transfer: blk_cnt increments, out_valid drops next cycle, state goes to FILL, and in_ready=1 in that same next cycle.
- No overlap: in_ready stays 0 in RUN and DRAIN; input back-pressure is the only flow control upstream.
- in_valid outside FILL is ignored. A changing in_data while in_ready=0 has no effect.
- core_valid outside RUN is ignored.
- Reset mid-operation aborts the current block. Partial input and output are discarded; err and blk_cnt clear.
- Latency: from last input transfer to first out_valid is at most 1 + max(WAIT_MIN, core latency) + 1 cycles.

Test Plan:
- Reset: assert rst=0 for 5 cycles mid-stream -> all outputs 0 and in_ready=0 during reset; in_ready=1 on the first edge after release.
- Raster ramp: ZIGZAG=0; in_data=0..63 with continuous valid; core model echoes core_in with valid 5 cycles after RUN entry -> out_data 0..63, out_last only on 63, blk_cnt=1, err=0.
- Zig-zag: ZIGZAG=1, same ramp -> out_data sequence 0,1,8,16,9,2,...,62,63 matching the ROM exactly.
- Back-pressure: drive out_ready with a random 50% pattern and in_valid gaps -> no beat lost, duplicated or changed while stalled; 64 beats; next block accepted only after beat 63.
- Stale valid / timeout:
  - core_valid held 1 across blocks -> capture occurs no earlier than WAIT_MIN cycles after RUN entry.
  - core_valid stuck 0 -> capture after 1024 RUN cycles, err=1 and sticky; 64 beats still drained; blk_cnt increments.
- Reset mid-DRAIN at beat 30 -> outputs 0 immediately; following block drains correctly with blk_cnt=1.
